// File: rtl/sb_tx_arbiter.sv
// Round-robin arbiter sharing the sideband TX message port among LTSM sub-state requesters.
// One message is issued per grant; a holdoff window follows each issue before re-arbitration.
module sb_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MSG_W   = 32,
    parameter int HOLDOFF = 2,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk_100MHz,
    input  logic                     reset,
    input  logic                     enable_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*MSG_W-1:0] req_msg_i,
    input  logic [NUM_REQ*64-1:0]    req_data_i,
    output logic [NUM_REQ-1:0]       req_ack_o,
    output logic [MSG_W-1:0]         SB_TX_msg_o,
    output logic [63:0]              SB_TX_dataBus_o,
    output logic                     SB_TX_msg_valid_o,
    input  logic                     SB_TX_msg_sendNextFlag_i,
    output logic                     busy_o,
    output logic [IDX_W-1:0]         grant_idx_o,
    output logic [15:0]              issued_cnt_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam int              HC_W      = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLDOFF - 1);

    logic [1:0]         state_r;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [IDX_W-1:0]   grant_idx_r;
    logic [HC_W-1:0]    hold_cnt_r;
    logic [15:0]        issued_cnt_r;
    logic [NUM_REQ-1:0] ack_r;
    logic               valid_r;
    logic               busy_r;
    logic [MSG_W-1:0]   msg_r;
    logic [63:0]        data_r;

    logic [IDX_W-1:0]   pick_idx_s;
    logic [IDX_W-1:0]   next_ptr_s;
    logic [NUM_REQ-1:0] grant_onehot_s;
    logic               grant_req_s;

    // First requester at or after ptr, wrapping; returns ptr when nothing is pending.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] sel;
        logic             found;
        int               idx;
        sel   = ptr;
        found = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(ptr) + off;
            idx = (idx >= NUM_REQ) ? (idx - NUM_REQ) : idx;
            if (!found && req[idx]) begin
                sel   = IDX_W'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return sel;
    endfunction

    // Arbitration decode: winner search, pointer successor and one-hot ack of the current grant.
    always_comb begin
        pick_idx_s     = rr_pick(req_valid_i, rr_ptr_r);
        grant_req_s    = req_valid_i[grant_idx_r];
        grant_onehot_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_onehot_s[i] = (grant_idx_r == IDX_W'(i));
        end
        if (int'(grant_idx_r) == NUM_REQ - 1) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = grant_idx_r + IDX_W'(1);
        end
    end

    // Control FSM and registered output stage; strobes default low every cycle.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= '0;
            grant_idx_r  <= '0;
            hold_cnt_r   <= '0;
            issued_cnt_r <= 16'd0;
            ack_r        <= '0;
            valid_r      <= 1'b0;
            busy_r       <= 1'b0;
            msg_r        <= '0;
            data_r       <= 64'd0;
        end else begin
            valid_r <= 1'b0;
            ack_r   <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (enable_i && (|req_valid_i)) begin
                        grant_idx_r <= pick_idx_s;
                        state_r     <= ST_GRANT;
                        busy_r      <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (!grant_req_s) begin
                        // Requester withdrew: drop the grant without touching the pointer.
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (SB_TX_msg_sendNextFlag_i) begin
                        valid_r      <= 1'b1;
                        ack_r        <= grant_onehot_s;
                        msg_r        <= req_msg_i[int'(grant_idx_r)*MSG_W +: MSG_W];
                        data_r       <= req_data_i[int'(grant_idx_r)*64 +: 64];
                        rr_ptr_r     <= next_ptr_s;
                        issued_cnt_r <= issued_cnt_r + 16'd1;
                        hold_cnt_r   <= '0;
                        state_r      <= ST_HOLD;
                        busy_r       <= 1'b1;
                    end else begin
                        state_r <= ST_GRANT;
                        busy_r  <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HC_W'(1);
                        busy_r     <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ack_o         = ack_r;
    assign SB_TX_msg_o       = msg_r;
    assign SB_TX_dataBus_o   = data_r;
    assign SB_TX_msg_valid_o = valid_r;
    assign busy_o            = busy_r;
    assign grant_idx_o       = grant_idx_r;
    assign issued_cnt_o      = issued_cnt_r;

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Directed bench for sb_tx_arbiter: a scoreboard queue of expected issues is filled as
// requests are driven and drained by a monitor that checks every issue strobe.
module tb_sb_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int MSG_W   = 32;
    localparam int HOLDOFF = 2;

    typedef struct packed {
        logic [1:0]       idx;
        logic [MSG_W-1:0] msg;
        logic [63:0]      data;
    } exp_t;

    logic                     clk_100MHz = 1'b0;
    logic                     reset;
    logic                     enable_i;
    logic [NUM_REQ-1:0]       req_valid_i;
    logic [NUM_REQ*MSG_W-1:0] req_msg_i;
    logic [NUM_REQ*64-1:0]    req_data_i;
    logic [NUM_REQ-1:0]       req_ack_o;
    logic [MSG_W-1:0]         SB_TX_msg_o;
    logic [63:0]              SB_TX_dataBus_o;
    logic                     SB_TX_msg_valid_o;
    logic                     SB_TX_msg_sendNextFlag_i;
    logic                     busy_o;
    logic [1:0]               grant_idx_o;
    logic [15:0]              issued_cnt_o;

    logic [MSG_W-1:0] msg_arr  [NUM_REQ];
    logic [63:0]      data_arr [NUM_REQ];
    exp_t             exp_q [$];
    exp_t             mon_e;
    logic [15:0]      model_cnt = 16'd0;
    int               pass_cnt = 0;
    int               fail_cnt = 0;
    int               cyc = 0;
    int               last_issue = -1;
    int               gap_exp = 0;

    sb_tx_arbiter #(.NUM_REQ(NUM_REQ), .MSG_W(MSG_W), .HOLDOFF(HOLDOFF)) dut (
        .clk_100MHz               (clk_100MHz),
        .reset                    (reset),
        .enable_i                 (enable_i),
        .req_valid_i              (req_valid_i),
        .req_msg_i                (req_msg_i),
        .req_data_i               (req_data_i),
        .req_ack_o                (req_ack_o),
        .SB_TX_msg_o              (SB_TX_msg_o),
        .SB_TX_dataBus_o          (SB_TX_dataBus_o),
        .SB_TX_msg_valid_o        (SB_TX_msg_valid_o),
        .SB_TX_msg_sendNextFlag_i (SB_TX_msg_sendNextFlag_i),
        .busy_o                   (busy_o),
        .grant_idx_o              (grant_idx_o),
        .issued_cnt_o             (issued_cnt_o)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    always @(posedge clk_100MHz) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_msg_i[i*MSG_W +: MSG_W] = msg_arr[i];
            req_data_i[i*64 +: 64]      = data_arr[i];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_100MHz);
        #1;
    endtask

    task automatic new_payload();
        for (int i = 0; i < NUM_REQ; i++) begin
            msg_arr[i]  = $urandom;
            data_arr[i] = {$urandom, $urandom};
        end
    endtask

    task automatic push(input int idx);
        exp_t e;
        e.idx  = 2'(idx);
        e.msg  = msg_arr[idx];
        e.data = data_arr[idx];
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(1);
        check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
        tick(HOLDOFF + 2);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 64'(SB_TX_msg_valid_o), 64'd0);
        check({tag, "_ack"},   64'(req_ack_o),         64'd0);
        check({tag, "_msg"},   64'(SB_TX_msg_o),       64'd0);
        check({tag, "_data"},  SB_TX_dataBus_o,        64'd0);
        check({tag, "_busy"},  64'(busy_o),            64'd0);
        check({tag, "_gidx"},  64'(grant_idx_o),       64'd0);
        check({tag, "_cnt"},   64'(issued_cnt_o),      64'd0);
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected issue.
    always @(negedge clk_100MHz) begin
        if (reset) begin
            model_cnt = 16'd0;
        end else if (SB_TX_msg_valid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_issue", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                model_cnt = model_cnt + 16'd1;
                check("issue_ack",  64'(req_ack_o),    64'(4'b0001 << mon_e.idx));
                check("issue_msg",  64'(SB_TX_msg_o),  64'(mon_e.msg));
                check("issue_data", SB_TX_dataBus_o,   mon_e.data);
                check("issue_gidx", 64'(grant_idx_o),  64'(mon_e.idx));
                check("issue_cnt",  64'(issued_cnt_o), 64'(model_cnt));
            end
            if (gap_exp != 0 && last_issue >= 0)
                check("issue_gap", 64'(cyc - last_issue), 64'(gap_exp));
            last_issue = cyc;
        end else begin
            check("quiet_ack", 64'(req_ack_o), 64'd0);
        end
    end

    initial begin
        reset = 1'b1;
        enable_i = 1'b1;
        req_valid_i = '0;
        SB_TX_msg_sendNextFlag_i = 1'b0;
        new_payload();
        tick(3);
        check_zero("reset");
        reset = 1'b0;

        // All four requesters continuously valid: 0,1,2,3,0 spaced HOLDOFF+2 apart.
        gap_exp = HOLDOFF + 2;
        last_issue = -1;
        for (int i = 0; i < 5; i++) push(i % NUM_REQ);
        req_valid_i = 4'b1111;
        SB_TX_msg_sendNextFlag_i = 1'b1;
        tick(18);
        check("rr5_valid", 64'(SB_TX_msg_valid_o), 64'd1);
        check("rr5_ack", 64'(req_ack_o), 64'd1);
        req_valid_i = '0;
        wait_drain("rr");
        gap_exp = 0;
        check("rr_cnt", 64'(issued_cnt_o), 64'd5);

        // Single request from requester 1: grant next cycle, issue the cycle after.
        new_payload();
        push(1);
        req_valid_i = 4'b0010;
        tick(1);
        check("single_busy", 64'(busy_o), 64'd1);
        check("single_gidx", 64'(grant_idx_o), 64'd1);
        check("single_early", 64'(SB_TX_msg_valid_o), 64'd0);
        tick(1);
        check("single_valid", 64'(SB_TX_msg_valid_o), 64'd1);
        check("single_ack", 64'(req_ack_o), 64'b0010);
        check("single_cnt", 64'(issued_cnt_o), 64'd6);
        req_valid_i = '0;
        wait_drain("single");

        // Back-pressure: serializer not ready for 10 cycles.
        push(0);
        req_valid_i = 4'b0001;
        SB_TX_msg_sendNextFlag_i = 1'b0;
        tick(1);
        for (int k = 0; k < 10; k++) begin
            check("bp_novalid", 64'(SB_TX_msg_valid_o), 64'd0);
            check("bp_busy", 64'(busy_o), 64'd1);
            tick(1);
        end
        SB_TX_msg_sendNextFlag_i = 1'b1;
        tick(1);
        check("bp_valid", 64'(SB_TX_msg_valid_o), 64'd1);
        check("bp_ack", 64'(req_ack_o), 64'b0001);
        req_valid_i = '0;
        wait_drain("bp");

        // Move the pointer to 2 by serving requester 1.
        push(1);
        req_valid_i = 4'b0010;
        tick(2);
        check("pre_abort_valid", 64'(SB_TX_msg_valid_o), 64'd1);
        req_valid_i = '0;
        wait_drain("pre_abort");

        // Abort: requester 2 withdraws while granted; pointer must stay at 2.
        req_valid_i = 4'b0100;
        SB_TX_msg_sendNextFlag_i = 1'b0;
        tick(2);
        check("abort_gidx", 64'(grant_idx_o), 64'd2);
        check("abort_busy", 64'(busy_o), 64'd1);
        req_valid_i = '0;
        tick(1);
        check("abort_idle", 64'(busy_o), 64'd0);
        check("abort_cnt", 64'(issued_cnt_o), 64'd8);
        push(2);
        req_valid_i = 4'b0101;
        SB_TX_msg_sendNextFlag_i = 1'b1;
        tick(2);
        check("post_abort_valid", 64'(SB_TX_msg_valid_o), 64'd1);
        check("post_abort_ack", 64'(req_ack_o), 64'b0100);
        req_valid_i = '0;
        wait_drain("post_abort");

        // Disabled arbiter ignores pending requests.
        enable_i = 1'b0;
        req_valid_i = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            check("disabled_busy", 64'(busy_o), 64'd0);
        end
        req_valid_i = '0;
        enable_i = 1'b1;
        tick(1);

        // Reset while granted (pointer 3 picks requester 3), then a fresh grant from pointer 0.
        new_payload();
        req_valid_i = 4'b1010;
        SB_TX_msg_sendNextFlag_i = 1'b0;
        tick(2);
        check("prereset_busy", 64'(busy_o), 64'd1);
        check("prereset_gidx", 64'(grant_idx_o), 64'd3);
        reset = 1'b1;
        tick(2);
        check_zero("midreset");
        push(1);
        SB_TX_msg_sendNextFlag_i = 1'b1;
        reset = 1'b0;
        tick(1);
        check("postreset_early", 64'(SB_TX_msg_valid_o), 64'd0);
        check("postreset_gidx", 64'(grant_idx_o), 64'd1);
        tick(1);
        check("postreset_valid", 64'(SB_TX_msg_valid_o), 64'd1);
        check("postreset_ack", 64'(req_ack_o), 64'b0010);
        check("postreset_cnt", 64'(issued_cnt_o), 64'd1);
        req_valid_i = '0;
        wait_drain("postreset");

        $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
        $finish;
    end

endmodule
